// File: rtl/idft_pkg.sv
// idft_pkg
// Shared definitions for the idft output stage: sample and frame sizes, the
// complex sample record stored in the frame buffer, and the 1/N rounding
// function applied to every sample on its way into the buffer.
package idft_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int FRAME_LOG2 = 3;
   localparam int FRAME_N    = 1 << FRAME_LOG2;

   typedef struct packed {
      logic [SAMPLE_W-1:0] re;
      logic [SAMPLE_W-1:0] im;
   } cplx_t;

   // 1/N normalisation with round-half-up: add half an output LSB, then
   // arithmetic shift. One guard bit keeps the bias addition from wrapping
   // at the positive extreme. After the shift the result always fits back
   // into SAMPLE_W bits, so plain truncation is exact.
   function automatic logic [SAMPLE_W-1:0] scale_round(input logic [SAMPLE_W-1:0] x);
      logic signed [SAMPLE_W:0] wide;
      wide = $signed({x[SAMPLE_W-1], x}) + $signed((SAMPLE_W+1)'(1 << (FRAME_LOG2-1)));
      wide = wide >>> FRAME_LOG2;
      return wide[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/idft_frame_buf.sv
// idft_frame_buf
// Two-bank ping-pong frame store, FRAME_N complex entries per bank.
// Ports:
//   clk            - clock, rising edge
//   we             - write enable
//   wbank, waddr   - bank and entry written at the clock edge
//   wdata          - complex sample to store
//   rbank, raddr   - bank and entry presented on rdata
//   rdata          - combinational read of the selected entry
module idft_frame_buf
   import idft_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic                  wbank,
   input  logic [FRAME_LOG2-1:0] waddr,
   input  cplx_t                 wdata,
   input  logic                  rbank,
   input  logic [FRAME_LOG2-1:0] raddr,
   output cplx_t                 rdata
);

   cplx_t mem [2][FRAME_N];

   // Storage needs no reset: a bank is only ever read after a complete frame
   // has been written into it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wbank][waddr] <= wdata;
      end
   end

   assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/idft_out_scaler.sv
// idft_out_scaler
// Scales the serial complex output of the idft by 1/N (round-half-up),
// collects each N-sample frame in a ping-pong buffer and replays it under a
// valid/ready handshake with first/last markers. Frames arriving while both
// banks are still occupied are dropped whole and flagged.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in, j_in, in_valid  - incoming sample stream, no back-pressure
//   out, j_out          - scaled sample, registered
//   out_valid/out_ready - output handshake
//   out_first/out_last  - word is sample 0 / sample N-1 of its frame
//   overflow            - one-cycle pulse per dropped input frame
module idft_out_scaler
   import idft_pkg::*;
#(
   parameter int BITS  = 15,
   parameter int LOG2N = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [BITS:0] in,
   input  logic [BITS:0] j_in,
   input  logic          in_valid,
   output logic [BITS:0] out,
   output logic [BITS:0] j_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_first,
   output logic          out_last,
   output logic          overflow
);

   localparam logic [LOG2N-1:0] LAST = LOG2N'((1 << LOG2N) - 1);

   logic             wbank;
   logic [LOG2N-1:0] wcnt;
   logic             drop;
   logic             rbank;
   logic [LOG2N-1:0] rcnt;
   logic [1:0]       full;

   logic             hs;
   logic             release_rd;
   logic [1:0]       full_cleared;
   logic [1:0]       full_nxt;
   logic [LOG2N-1:0] rcnt_nxt;
   logic             rbank_nxt;
   logic             avail;
   logic             frame_start;
   logic             drop_start;
   logic             drop_eff;
   logic             we;
   logic             wr_done;
   cplx_t            wdata;
   cplx_t            rdata;

   assign wdata.re = scale_round(in);
   assign wdata.im = scale_round(j_in);

   idft_frame_buf u_buf (
      .clk   (clk),
      .we    (we),
      .wbank (wbank),
      .waddr (wcnt),
      .wdata (wdata),
      .rbank (rbank_nxt),
      .raddr (rcnt_nxt),
      .rdata (rdata)
   );

   // Read and write control. The reader's release of a bank is applied to
   // the full flags before the writer looks at them, so a frame starting on
   // the bank being freed in the same cycle is accepted. The output register
   // is loaded from the bank state as it stood before this edge, which gives
   // a completed frame one cycle before its first word appears.
   always_comb begin
      hs           = out_valid & out_ready;
      release_rd   = hs & (rcnt == LAST);
      full_cleared = full;
      if (release_rd) begin
         full_cleared[rbank] = 1'b0;
      end
      rcnt_nxt  = hs ? rcnt + 1'b1 : rcnt;
      rbank_nxt = release_rd ? ~rbank : rbank;
      avail     = full_cleared[rbank_nxt];

      frame_start = in_valid & (wcnt == '0);
      drop_start  = frame_start & full_cleared[wbank];
      drop_eff    = frame_start ? drop_start : drop;
      we          = in_valid & ~drop_eff;
      wr_done     = we & (wcnt == LAST);
      full_nxt    = full_cleared;
      if (wr_done) begin
         full_nxt[wbank] = 1'b1;
      end
   end

   // State and output registers. Dropped frames still advance wcnt so the
   // writer stays aligned to frame boundaries. Output data is forced to zero
   // whenever no word is on offer.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbank     <= 1'b0;
         wcnt      <= '0;
         drop      <= 1'b0;
         rbank     <= 1'b0;
         rcnt      <= '0;
         full      <= 2'b00;
         out       <= '0;
         j_out     <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         full      <= full_nxt;
         rcnt      <= rcnt_nxt;
         rbank     <= rbank_nxt;
         out_valid <= avail;
         out       <= avail ? rdata.re : '0;
         j_out     <= avail ? rdata.im : '0;
         overflow  <= drop_start;
         if (in_valid) begin
            wcnt <= wcnt + 1'b1;
            drop <= (wcnt == LAST) ? 1'b0 : drop_eff;
            if (wr_done) begin
               wbank <= ~wbank;
            end
         end
      end
   end

   assign out_first = out_valid & (rcnt == '0);
   assign out_last  = out_valid & (rcnt == LAST);

endmodule
